dart_turn_ctrl: RTL and testbench

- Sequences the dart scoring engine. That engine alternates players one dart per turn and is driven by a dart_come pulse with a 4-bit x/y position.
- Accepts throws from the board sensor over a valid/ready handshake and forwards exactly one throw per turn. It then waits for the engine's per-player done indication.
- Tracks whose turn it is and the round count. Injects a zero-score miss when a player stalls, declares a draw at the round limit, and flags protocol errors.
- Sits between the sensor front-end and the scoring engine.

---
 rtl/dart_turn_ctrl_if.sv | 25 ++
 rtl/dart_turn_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dart_turn_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dart_turn_ctrl_if.sv
// Sensor-side throw handshake plus engine-side dart issue / done signals.
interface dart_turn_if;
    logic       throw_valid_i;
    logic [3:0] throw_x_i;
    logic [3:0] throw_y_i;
    logic       throw_ready_o;
    logic       dart_come_o;
    logic [3:0] dart_position_x_o;
    logic [3:0] dart_position_y_o;
    logic       player_1_done_i;
    logic       player_2_done_i;
    logic       game_set_i;

    modport slave (
        input  throw_valid_i, throw_x_i, throw_y_i,
        input  player_1_done_i, player_2_done_i, game_set_i,
        output throw_ready_o, dart_come_o, dart_position_x_o, dart_position_y_o
    );

    modport master (
        output throw_valid_i, throw_x_i, throw_y_i,
        output player_1_done_i, player_2_done_i, game_set_i,
        input  throw_ready_o, dart_come_o, dart_position_x_o, dart_position_y_o
    );
endinterface

// File: rtl/dart_turn_ctrl.sv
// Turn sequencer between the throw sensor and the dart scoring engine.
// Define DART_THROW_TIMEOUT_EN to inject a zero-score miss when a player stalls.
module dart_turn_ctrl #(
    parameter int MAX_ROUNDS    = 20,
    parameter int THROW_TIMEOUT = 1000,
    parameter int DONE_TIMEOUT  = 16,
    parameter int CNT_W         = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    dart_turn_if.slave  bus,
    output logic        cur_player_o,
    output logic [4:0]  round_o,
    output logic        timeout_o,
    output logic [1:0]  winner_o,
    output logic        draw_o,
    output logic        error_o,
    output logic        game_over_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_THROW, S_ISSUE, S_WAIT_DONE, S_OVER
    } state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } pos_t;

    localparam logic [4:0]       MAX_R     = 5'(MAX_ROUNDS);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pos_t             pos_q, pos_d;
    pos_t             in_pos;
    logic             player_q, player_d;
    logic [4:0]       round_q, round_d;
    logic [1:0]       winner_q, winner_d;
    logic             draw_q, draw_d;
    logic             error_q, error_d;
    logic             exp_done, oth_done;

`ifdef DART_THROW_TIMEOUT_EN
    localparam logic [CNT_W-1:0] THROW_LAST = CNT_W'(THROW_TIMEOUT - 1);
    logic timeout_q, timeout_d;
`endif

    // Off-board coordinates are remapped to (0,0), which the engine scores as 0.
    always_comb begin
        in_pos = '{x: bus.throw_x_i, y: bus.throw_y_i};
        if (bus.throw_x_i > 4'd9 || bus.throw_y_i > 4'd9)
            in_pos = '0;
    end

    assign exp_done = player_q ? bus.player_2_done_i : bus.player_1_done_i;
    assign oth_done = player_q ? bus.player_1_done_i : bus.player_2_done_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        player_d = player_q;
        round_d  = round_q;
        winner_d = winner_q;
        draw_d   = draw_q;
        error_d  = error_q;
`ifdef DART_THROW_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    player_d = 1'b0;
                    round_d  = 5'd1;
                    cnt_d    = '0;
                    state_d  = S_WAIT_THROW;
                end
            end
            S_WAIT_THROW: begin
                if (bus.throw_valid_i) begin
                    pos_d   = in_pos;
                    state_d = S_ISSUE;
                end
`ifdef DART_THROW_TIMEOUT_EN
                else if (cnt_q == THROW_LAST) begin
                    pos_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = S_ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A done from the idle player (alone or with the right one) is a protocol error.
                if (oth_done) begin
                    error_d = 1'b1;
                    state_d = S_OVER;
                end else if (exp_done) begin
                    if (bus.game_set_i) begin
                        winner_d = player_q ? 2'b10 : 2'b01;
                        state_d  = S_OVER;
                    end else if (player_q && round_q == MAX_R) begin
                        draw_d  = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        player_d = ~player_q;
                        if (player_q && round_q < MAX_R)
                            round_d = round_q + 5'd1;
                        cnt_d    = '0;
                        state_d  = S_WAIT_THROW;
                    end
                end else if (cnt_q == DONE_LAST) begin
                    error_d = 1'b1;
                    state_d = S_OVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OVER: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pos_q    <= '0;
            player_q <= 1'b0;
            round_q  <= 5'd0;
            winner_q <= 2'b00;
            draw_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            player_q <= player_d;
            round_q  <= round_d;
            winner_q <= winner_d;
            draw_q   <= draw_d;
            error_q  <= error_d;
        end
    end

`ifdef DART_THROW_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timeout_q <= 1'b0;
        else        timeout_q <= timeout_d;
    end
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign bus.throw_ready_o     = (state_q == S_WAIT_THROW);
    assign bus.dart_come_o       = (state_q == S_ISSUE);
    assign bus.dart_position_x_o = pos_q.x;
    assign bus.dart_position_y_o = pos_q.y;
    assign cur_player_o          = player_q;
    assign round_o               = round_q;
    assign winner_o              = winner_q;
    assign draw_o                = draw_q;
    assign error_o               = error_q;
    assign game_over_o           = (state_q == S_OVER);
endmodule

// File: tb/tb_dart_turn_ctrl.sv
// Self-checking bench for dart_turn_ctrl: directed scenarios plus random games vs. a rule-level model.
module tb_dart_turn_ctrl;
    localparam int MAX_ROUNDS    = 2;
    localparam int THROW_TIMEOUT = 8;
    localparam int DONE_TIMEOUT  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_i;
    logic       cur_player_o;
    logic [4:0] round_o;
    logic       timeout_o;
    logic [1:0] winner_o;
    logic       draw_o, error_o, game_over_o;

    int tests = 0;
    int fails = 0;

    dart_turn_if bus ();

    dart_turn_ctrl #(
        .MAX_ROUNDS(MAX_ROUNDS), .THROW_TIMEOUT(THROW_TIMEOUT),
        .DONE_TIMEOUT(DONE_TIMEOUT), .CNT_W(10)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .bus(bus),
        .cur_player_o(cur_player_o), .round_o(round_o), .timeout_o(timeout_o),
        .winner_o(winner_o), .draw_o(draw_o), .error_o(error_o),
        .game_over_o(game_over_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rule-level model: where the game is, how long the current wait has lasted, and the tallies.
    typedef enum {M_IDLE, M_THROW, M_ISSUE, M_DONE, M_OVER} mph_t;
    mph_t mph;
    int   m_wait, m_player, m_round, m_x, m_y, m_winner;
    bit   m_miss, m_draw, m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mph <= M_IDLE; m_wait <= 0; m_player <= 0; m_round <= 0;
            m_x <= 0; m_y <= 0; m_winner <= 0; m_miss <= 0; m_draw <= 0; m_err <= 0;
        end else begin
            case (mph)
                M_IDLE: if (start_i) begin
                    m_player <= 0; m_round <= 1; m_wait <= 0; mph <= M_THROW;
                end
                M_THROW: begin
                    if (bus.throw_valid_i) begin
                        if (bus.throw_x_i > 9 || bus.throw_y_i > 9) begin
                            m_x <= 0; m_y <= 0;
                        end else begin
                            m_x <= bus.throw_x_i; m_y <= bus.throw_y_i;
                        end
                        mph <= M_ISSUE;
                    end
`ifdef DART_THROW_TIMEOUT_EN
                    else begin
                        m_wait <= m_wait + 1;
                        if (m_wait + 1 == THROW_TIMEOUT) begin
                            m_x <= 0; m_y <= 0; m_miss <= 1; mph <= M_ISSUE;
                        end
                    end
`endif
                end
                M_ISSUE: begin
                    m_miss <= 0; m_wait <= 0; mph <= M_DONE;
                end
                M_DONE: begin
                    bit mine, other;
                    mine  = (m_player == 0) ? bus.player_1_done_i : bus.player_2_done_i;
                    other = (m_player == 0) ? bus.player_2_done_i : bus.player_1_done_i;
                    if (other) begin
                        m_err <= 1; mph <= M_OVER;
                    end else if (mine) begin
                        if (bus.game_set_i) begin
                            m_winner <= m_player + 1; mph <= M_OVER;
                        end else if (m_player == 1 && m_round == MAX_ROUNDS) begin
                            m_draw <= 1; mph <= M_OVER;
                        end else begin
                            if (m_player == 1) m_round <= (m_round + 1 > MAX_ROUNDS) ? MAX_ROUNDS : m_round + 1;
                            m_player <= 1 - m_player; m_wait <= 0; mph <= M_THROW;
                        end
                    end else begin
                        m_wait <= m_wait + 1;
                        if (m_wait + 1 == DONE_TIMEOUT) begin
                            m_err <= 1; mph <= M_OVER;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("ready",     bus.throw_ready_o,     mph == M_THROW);
        chk("dart_come", bus.dart_come_o,       mph == M_ISSUE);
        chk("pos_x",     bus.dart_position_x_o, m_x);
        chk("pos_y",     bus.dart_position_y_o, m_y);
        chk("player",    cur_player_o,          m_player);
        chk("round",     round_o,               m_round);
        chk("timeout",   timeout_o,             (mph == M_ISSUE) && m_miss);
        chk("winner",    winner_o,              m_winner);
        chk("draw",      draw_o,                m_draw);
        chk("error",     error_o,               m_err);
        chk("game_over", game_over_o,           mph == M_OVER);
    end

    // All directed tasks start and end just after a falling edge.
    task automatic clr_in();
        start_i = 0; bus.throw_valid_i = 0; bus.throw_x_i = 0; bus.throw_y_i = 0;
        bus.player_1_done_i = 0; bus.player_2_done_i = 0; bus.game_set_i = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        #1;
        @(posedge clk); #2;
        reset = 1;
        @(negedge clk);
    endtask

    task automatic do_start();
        start_i = 1;
        @(posedge clk); #2;
        start_i = 0;
        @(negedge clk);
    endtask

    task automatic do_throw(input int x, input int y);
        bit acc = 0;
        bus.throw_valid_i = 1; bus.throw_x_i = 4'(x); bus.throw_y_i = 4'(y);
        for (int i = 0; i < 40; i++) begin
            if (bus.throw_ready_o) begin acc = 1; break; end
            @(negedge clk);
        end
        @(posedge clk); #2;
        bus.throw_valid_i = 0;
        @(negedge clk);
        chk("throw_accepted", acc, 1);
        chk("accept_to_come", bus.dart_come_o, 1);
    endtask

    task automatic do_done(input bit p1, input bit p2, input bit gs, input int delay);
        repeat (delay) begin @(posedge clk); #2; end
        bus.player_1_done_i = p1; bus.player_2_done_i = p2; bus.game_set_i = gs;
        @(posedge clk); #2;
        bus.player_1_done_i = 0; bus.player_2_done_i = 0; bus.game_set_i = 0;
        @(negedge clk);
    endtask

    task automatic rand_game();
        int  cd;
        bit  acc_pend;
        cd = -1; acc_pend = 0;
        do_reset();
        do_start();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (game_over_o) break;
            bus.player_1_done_i = 0; bus.player_2_done_i = 0; bus.game_set_i = 0;
            if (acc_pend) begin
                bus.throw_valid_i = 0; acc_pend = 0;
            end else if (!bus.throw_valid_i && $urandom_range(2) == 0) begin
                bus.throw_valid_i = 1;
                bus.throw_x_i = 4'($urandom_range(15));
                bus.throw_y_i = 4'($urandom_range(15));
            end
            if (bus.throw_valid_i && bus.throw_ready_o) acc_pend = 1;
            if (bus.dart_come_o) begin
                cd = ($urandom_range(24) == 0) ? -1 : int'($urandom_range(1, 3));
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    int r = $urandom_range(15);
                    bus.game_set_i = ($urandom_range(7) == 0);
                    if (r == 0)      begin bus.player_1_done_i = cur_player_o;  bus.player_2_done_i = ~cur_player_o; end
                    else if (r == 1) begin bus.player_1_done_i = 1; bus.player_2_done_i = 1; end
                    else             begin bus.player_1_done_i = ~cur_player_o; bus.player_2_done_i = cur_player_o; end
                    cd = -1;
                end
            end
        end
        clr_in();
        @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  seen;
        clr_in();
        #1 reset = 0;
        #1;
        chk("rst_round",  round_o, 0);
        chk("rst_over",   game_over_o, 0);
        chk("rst_ready",  bus.throw_ready_o, 0);
        chk("rst_come",   bus.dart_come_o, 0);
        @(posedge clk); #2;
        reset = 1;
        @(negedge clk);

        // Full game to a draw at MAX_ROUNDS = 2.
        do_start();
        chk("start_ready", bus.throw_ready_o, 1);
        chk("start_round", round_o, 1);
        do_throw(5, 2);
        chk("t52_x", bus.dart_position_x_o, 5);
        chk("t52_y", bus.dart_position_y_o, 2);
        do_done(1, 0, 0, 2);
        chk("p1done_player", cur_player_o, 1);
        chk("p1done_round",  round_o, 1);
        chk("p1done_ready",  bus.throw_ready_o, 1);
        do_throw(12, 3);
        chk("offb_x", bus.dart_position_x_o, 0);
        chk("offb_y", bus.dart_position_y_o, 0);
        do_done(0, 1, 0, 2);
        chk("r2_round",  round_o, 2);
        chk("r2_player", cur_player_o, 0);
        chk("r2_error",  error_o, 0);
        do_throw(1, 1);
        do_done(1, 0, 0, 1);
        do_throw(9, 9);
        chk("edge99_x", bus.dart_position_x_o, 9);
        chk("edge99_y", bus.dart_position_y_o, 9);
        do_done(0, 1, 0, 3);
        chk("draw",       draw_o, 1);
        chk("draw_over",  game_over_o, 1);
        chk("draw_ready", bus.throw_ready_o, 0);
        do_start();
        chk("over_ignores_start", game_over_o, 1);

        // Reset in WAIT_DONE aborts immediately; restart from round 1, player 1.
        do_reset();
        do_start();
        do_throw(3, 4);
        @(negedge clk);
        reset = 0;
        #1;
        chk("midrst_round", round_o, 0);
        chk("midrst_x",     bus.dart_position_x_o, 0);
        chk("midrst_come",  bus.dart_come_o, 0);
        @(posedge clk); #2;
        reset = 1;
        @(negedge clk);
        do_start();
        chk("restart_round",  round_o, 1);
        chk("restart_player", cur_player_o, 0);

        // Player 2 wins in round 1.
        do_throw(2, 2);
        do_done(1, 0, 0, 2);
        do_throw(7, 8);
        do_done(0, 1, 1, 2);
        chk("win_p2",  winner_o, 2);
        chk("win_over", game_over_o, 1);

        // Player 1's done while player 2 is up.
        do_reset();
        do_start();
        do_throw(4, 4);
        do_done(1, 0, 0, 1);
        do_throw(4, 5);
        do_done(1, 0, 0, 1);
        chk("wrong_done_err", error_o, 1);

        // Engine never answers: error exactly after DONE_TIMEOUT cycles.
        do_reset();
        do_start();
        do_throw(6, 6);
        repeat (DONE_TIMEOUT) @(negedge clk);
        chk("done_to_before", error_o, 0);
        @(negedge clk);
        chk("done_to_err", error_o, 1);

        do_reset();
        do_start();
`ifdef DART_THROW_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.dart_come_o) break;
            if (bus.throw_ready_o) n++;
            @(negedge clk);
        end
        chk("miss_wait_cycles", n, THROW_TIMEOUT);
        chk("miss_timeout",     timeout_o, 1);
        chk("miss_x",           bus.dart_position_x_o, 0);
        do_done(1, 0, 0, 2);
        repeat (THROW_TIMEOUT - 2) @(negedge clk);
        do_throw(8, 1);
        chk("late_valid_no_to", timeout_o, 0);
        chk("late_valid_x",     bus.dart_position_x_o, 8);
`else
        seen = 0;
        for (int i = 0; i < 3 * THROW_TIMEOUT; i++) begin
            @(negedge clk);
            if (bus.dart_come_o) seen = 1;
        end
        chk("no_miss_come",  seen, 0);
        chk("no_miss_ready", bus.throw_ready_o, 1);
`endif

        for (int g = 0; g < 40; g++) rand_game();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end
endmodule
